// File: rtl/hint_text_pkg.sv
// Shared constants for the hint/menu text buffer: geometry defaults, blank code, FSM states.
package hint_text_pkg;

   localparam int unsigned DEF_LINES  = 12;
   localparam int unsigned DEF_COLS   = 35;
   localparam int unsigned DEF_CODE_W = 5;

   // Fixed index widths seen by producer and renderer
   localparam int unsigned LINE_W = 4;
   localparam int unsigned COL_W  = 6;

   // Code 0 renders as an empty cell
   localparam logic [DEF_CODE_W-1:0] BLANK = '0;

   // FSM state encoding
   localparam int unsigned ST_W = 3;
   localparam logic [ST_W-1:0] ST_CLEAR   = 3'd0;
   localparam logic [ST_W-1:0] ST_IDLE    = 3'd1;
   localparam logic [ST_W-1:0] ST_WRITE   = 3'd2;
   localparam logic [ST_W-1:0] ST_DISCARD = 3'd3;
   localparam logic [ST_W-1:0] ST_PAD     = 3'd4;

endpackage

// File: rtl/hint_char_ram.sv
// Simple dual-port character RAM: synchronous write, registered read returning old data on collision.
module hint_char_ram #(
   parameter int unsigned DEPTH = 420,
   parameter int unsigned AW    = 9,
   parameter int unsigned DW    = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd,
   input  logic          rd_hit,
   input  logic [AW-1:0] ra,
   output logic [DW-1:0] rd
);

   logic [DW-1:0] mem [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wa] <= wd;
      end
   end

   // Read port; out-of-range lookups return blank
   always_ff @(posedge clk) begin
      if (rst) begin
         rd <= '0;
      end else if (rd_hit) begin
         rd <= mem[ra];
      end else begin
         rd <= '0;
      end
   end

endmodule

// File: rtl/hint_text_buffer.sv
// Hint/menu text buffer: accepts per-line character strings, blank-pads each line,
// clears the whole buffer after reset, and serves the renderer through a registered read port.
module hint_text_buffer
   import hint_text_pkg::*;
#(
   parameter int unsigned LINES  = DEF_LINES,
   parameter int unsigned COLS   = DEF_COLS,
   parameter int unsigned CODE_W = DEF_CODE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic              wr_first,
   input  logic              wr_last,
   input  logic [LINE_W-1:0] wr_line,
   input  logic [CODE_W-1:0] wr_code,
   output logic              done,
   output logic              err,
   output logic              busy,
   input  logic [LINE_W-1:0] rd_line,
   input  logic [COL_W-1:0]  rd_col,
   output logic [CODE_W-1:0] rd_code
);

   localparam int unsigned DEPTH = LINES * COLS;
   localparam int unsigned AW    = $clog2(DEPTH);

   logic [ST_W-1:0]   state_q, state_n;
   logic [COL_W-1:0]  col_q, col_n;
   logic [AW-1:0]     clr_q, clr_n;
   logic [LINE_W-1:0] line_q, line_n;
   logic              line_ok_q, line_ok_n;
   logic              err_seen_q, err_seen_n;
   logic              done_n, err_n, wr_ready_n, busy_n;

   logic              accept_c;
   logic              last_col_c;
   logic              wr_line_ok_c;
   logic              we_c;
   logic [CODE_W-1:0] wd_c;
   logic [LINE_W-1:0] wline_c;
   logic [COL_W-1:0]  wcol_c;
   logic [AW-1:0]     wa_c;
   logic              rd_hit_c;
   logic [AW-1:0]     ra_c;

   assign accept_c     = wr_valid & wr_ready;
   assign last_col_c   = (col_q == COL_W'(COLS - 1));
   assign wr_line_ok_c = (32'(wr_line) < LINES);

   // Renderer address decode and range qualification
   assign rd_hit_c = (32'(rd_line) < LINES) && (32'(rd_col) < COLS);
   assign ra_c     = AW'(32'(rd_line) * COLS + 32'(rd_col));

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_CLEAR;
         col_q      <= '0;
         clr_q      <= '0;
         line_q     <= '0;
         line_ok_q  <= 1'b0;
         err_seen_q <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         wr_ready   <= 1'b0;
         busy       <= 1'b1;
      end else begin
         state_q    <= state_n;
         col_q      <= col_n;
         clr_q      <= clr_n;
         line_q     <= line_n;
         line_ok_q  <= line_ok_n;
         err_seen_q <= err_seen_n;
         done       <= done_n;
         err        <= err_n;
         wr_ready   <= wr_ready_n;
         busy       <= busy_n;
      end
   end

   // Next-state, RAM write request and pulse generation
   always_comb begin
      state_n    = state_q;
      col_n      = col_q;
      clr_n      = clr_q;
      line_n     = line_q;
      line_ok_n  = line_ok_q;
      err_seen_n = err_seen_q;
      done_n     = 1'b0;
      err_n      = 1'b0;
      we_c       = 1'b0;
      wd_c       = CODE_W'(BLANK);
      wline_c    = line_q;
      wcol_c     = col_q;

      case (state_q)
         ST_CLEAR: begin
            we_c = 1'b1;
            if (clr_q == AW'(DEPTH - 1)) begin
               state_n = ST_IDLE;
            end else begin
               clr_n = clr_q + AW'(1);
            end
         end

         ST_IDLE: begin
            if (accept_c) begin
               if (!wr_first) begin
                  // Stray continuation beat: drop it
                  err_n = 1'b1;
               end else if (wr_line_ok_c) begin
                  we_c    = 1'b1;
                  wd_c    = wr_code;
                  wline_c = wr_line;
                  wcol_c  = '0;
                  line_n  = wr_line;
                  col_n   = COL_W'(1);
                  if (!wr_last) begin
                     state_n = ST_WRITE;
                  end else if (COLS == 1) begin
                     state_n = ST_IDLE;
                     done_n  = 1'b1;
                  end else begin
                     state_n = ST_PAD;
                  end
               end else begin
                  // Bad line index: swallow the rest of the string without writing
                  err_n      = 1'b1;
                  line_ok_n  = 1'b0;
                  err_seen_n = 1'b1;
                  if (!wr_last) begin
                     state_n = ST_DISCARD;
                  end
               end
            end
         end

         ST_WRITE: begin
            if (accept_c) begin
               we_c = 1'b1;
               wd_c = wr_code;
               if (last_col_c) begin
                  if (wr_last) begin
                     state_n = ST_IDLE;
                     done_n  = 1'b1;
                  end else begin
                     // Line full but string continues: keep the truncated text
                     state_n    = ST_DISCARD;
                     line_ok_n  = 1'b1;
                     err_seen_n = 1'b0;
                  end
               end else begin
                  col_n = col_q + COL_W'(1);
                  if (wr_last) begin
                     state_n = ST_PAD;
                  end
               end
            end
         end

         ST_DISCARD: begin
            if (accept_c) begin
               if (!err_seen_q) begin
                  err_n      = 1'b1;
                  err_seen_n = 1'b1;
               end
               if (wr_last) begin
                  state_n = ST_IDLE;
                  done_n  = line_ok_q;
               end
            end
         end

         ST_PAD: begin
            we_c = 1'b1;
            if (last_col_c) begin
               state_n = ST_IDLE;
               done_n  = 1'b1;
            end else begin
               col_n = col_q + COL_W'(1);
            end
         end

         default: begin
            state_n = ST_CLEAR;
            clr_n   = '0;
         end
      endcase

      wa_c = (state_q == ST_CLEAR) ? clr_q
                                   : AW'(32'(wline_c) * COLS + 32'(wcol_c));

      wr_ready_n = (state_n == ST_IDLE) || (state_n == ST_WRITE) || (state_n == ST_DISCARD);
      busy_n     = (state_n == ST_CLEAR) || (state_n == ST_PAD);
   end

   hint_char_ram #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (CODE_W)
   ) u_ram (
      .clk    (clk),
      .rst    (rst),
      .we     (we_c & ~rst),
      .wa     (wa_c),
      .wd     (wd_c),
      .rd_hit (rd_hit_c),
      .ra     (ra_c),
      .rd     (rd_code)
   );

endmodule

// File: doc/hint_text_buffer.md
# hint_text_buffer

Writable character buffer for the on-screen hint/menu text. A control-side producer streams 5-bit character codes per text line over a valid/ready handshake. The block stores them in a LINES×COLS character RAM, blank-padding the rest of the line, while the pixel-side renderer reads codes by (line, column) through a registered read port. It is the write end of the character-code path that the renderer consumes before font lookup.

## Interface
- LINES, default 12: number of text lines.
- COLS, default 35: characters per line.
- CODE_W, default 5: character code width; code 0 is blank.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  producer beat valid.
- wr_ready  out  1  block accepts the beat this cycle.
- wr_first  in  1  beat is the first character of a line string.
- wr_last  in  1  beat is the last character of the string.
- wr_line  in  4  target line; sampled only on an accepted first beat.
- wr_code  in  CODE_W  character code.
- done  out  1  one-cycle pulse: string fully committed, including padding.
- err  out  1  one-cycle pulse: protocol or range error.
- busy  out  1  clear or pad in progress.
- rd_line  in  4  renderer line index.
- rd_col  in  6  renderer column index.
- rd_code  out  CODE_W  code at (rd_line, rd_col), one-cycle latency.

## Operation
- Address is line*COLS+col; the RAM holds LINES*COLS entries.
- A beat is accepted when wr_valid and wr_ready are both high.
- FSM states: CLEAR, IDLE, WRITE, DISCARD, PAD.
- **CLEAR**, entered on rst:
  - Writes 0 to addresses 0..LINES*COLS-1, one per cycle.
  - wr_ready=0, busy=1.
  - Goes to IDLE with no done pulse.
- **IDLE**: wr_ready=1.
  - Accepted beat with wr_first=1 and wr_line<LINES: latch the line and write the code at col 0. If wr_last, go to PAD with col=1; otherwise go to WRITE with col=1.
  - wr_first=1 with wr_line≥LINES: err pulse. Go to DISCARD, or return to IDLE if wr_last.
  - wr_first=0: beat dropped, err pulse.
- **WRITE**: wr_ready=1. Each accepted beat writes at col, then col increments. wr_first is ignored here.
  - wr_last at col<COLS-1: go to PAD.
  - wr_last at col==COLS-1: go to IDLE with done.
  - Beat at col==COLS-1 without wr_last: write it, then go to DISCARD.
- **DISCARD**: wr_ready=1.
  - Accepted beats are dropped, with no RAM write.
  - err pulses once, on the first dropped beat.
  - wr_last returns to IDLE. done pulses only if the line was valid; the truncated string is kept.
- **PAD**: wr_ready=0, busy=1. Writes 0 at col..COLS-1, one per cycle, then goes to IDLE.
- **Read port**: rd_code is registered from the RAM.
  - Out-of-range rd_line/rd_col returns 0.
  - If a read and a write hit the same address in the same cycle, the read returns the old data.

## Timing
- Reset values: wr_ready=0, done=0, err=0, busy=1, rd_code=0.
- Clear takes LINES*COLS cycles (420 at defaults); wr_ready rises in the cycle after the final clear write.
- A string of n<COLS characters, accepted back-to-back, takes n accept cycles plus COLS-n pad cycles.
- done is registered: it is high in the first IDLE cycle after the last write.
- With wr_valid held high, the next first-beat can be accepted in the same cycle that done is high.
- err is registered: it is high the cycle after the offending beat.
- rst mid-string or mid-pad: FSM returns to CLEAR and the partial string is lost. Reads during CLEAR are legal and return whatever the RAM currently holds.
- The read port is never stalled by write activity.

## Structure
- Package hint_text_pkg holds LINES, COLS and CODE_W defaults, the BLANK=0 constant, and the FSM state enum.
- Sub-module hint_char_ram: simple dual-port RAM with one synchronous write port and one registered read port (read-old-data on collision); maps to BRAM.
- Top level holds the FSM, column and clear counters, address computation, and pulse generation.

## Test plan
- **Reset clear**: assert rst for 1 cycle. Expect busy=1 for 420 cycles, then wr_ready=1; every address reads 0.
- **Short string**: line 3, codes 12,5,13,15,14 (last on the 5th beat). Expect 30 pad cycles, then done. (3,0..4) read 12,5,13,15,14; (3,5..34) read 0.
- **Full line**: 35 beats to line 11, with wr_last on beat 35. Expect no pad and done the next cycle; (11,34) returns the last code.
- **Overflow**: 40 beats to line 0, with last on beat 40. Expect err once, on beat 36. Columns 0..34 hold beats 1..35, and done pulses after beat 40.
- **Protocol errors**:
  - A beat with wr_first=0 in IDLE gives err and no RAM write.
  - wr_line=13 with 3 beats gives err, no writes and no done.
- **Read/write collision and mid-string reset**: read (2,0) while it is being written from 7 to 9; expect 7, then 9 on the following read. Then rst during a pad: the whole buffer reads 0 after 420 cycles.
